// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state/op enums and key codes for the signed calculator controller
package calc_pkg;

  typedef enum logic [2:0] {
    OP1, OP2, SEND, WAIT, RESULT, ERROR
  } calc_state_t;

  typedef enum logic {
    ADD, SUB
  } calc_op_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_NEG = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_entry.sv
// rtl/calc_entry.sv - one decimal operand: magnitude, sign, digit count and range check
module calc_entry
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic             load_i,
  input  logic             digit_i,
  input  logic             neg_i,
  input  logic [3:0]       digit_val_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             accept_o,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] value_next_o
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH+3:0] MAX_MAG = {5'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] mag_q, mag_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH+3:0] prod;

  // Four guard bits keep mag*10+d from wrapping before the range compare.
  assign prod     = ({4'b0, mag_q} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, digit_val_i};
  assign accept_o = (cnt_q < CW'(MAX_DIGITS)) && (prod <= MAX_MAG);

  always_comb begin
    mag_d  = mag_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      mag_d  = '0;
      sign_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      mag_d  = WIDTH'(digit_val_i);
      sign_d = 1'b0;
      cnt_d  = CW'(1);
    end else if (load_i) begin
      mag_d  = load_val_i[WIDTH-1] ? -load_val_i : load_val_i;
      sign_d = load_val_i[WIDTH-1];
      cnt_d  = '0;
    end else if (digit_i && accept_o) begin
      mag_d = prod[WIDTH-1:0];
      cnt_d = cnt_q + CW'(1);
    end else if (neg_i) begin
      sign_d = ~sign_q;
    end
  end

  assign value_o      = sign_q ? -mag_q : mag_q;
  assign value_next_o = sign_d ? -mag_d : mag_d;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mag_q  <= mag_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - signed add/sub calculator controller; CALC_CHAIN_EN lets an operator reuse the result
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int AW         = 4,
  parameter int MEM_BASE   = 0
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_sub,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_finish,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] display_output,
  output logic             complete,
  output logic             error,
  output logic             key_reject
);

  localparam logic [AW-1:0] ADDR_OP1 = AW'(MEM_BASE);
  localparam logic [AW-1:0] ADDR_OP2 = AW'(MEM_BASE + 1);
  localparam logic [AW-1:0] ADDR_RES = AW'(MEM_BASE + 2);

  calc_state_t      state_q;
  calc_op_t         op_q, key_op;
  logic             op2_dig_q;
  logic [WIDTH-1:0] alu_in1_q, alu_in2_q, mem_wdata_q, display_q;
  logic [AW-1:0]    mem_addr_q;
  logic             alu_sub_q, alu_start_q, mem_we_q, complete_q, error_q, key_reject_q;

  logic             is_dig, is_op, clr_all;
  logic             e1_start, e1_load, e1_dig, e1_neg, e2_clr, e2_dig, e2_neg;
  logic             e1_acc, e2_acc, cur_acc, cur_wr, ovf;
  logic [WIDTH-1:0] e1_val, e2_val, e1_next, e2_next, cur_next;
  logic [AW-1:0]    cur_addr;

  assign is_dig = is_digit(key_code);
  assign is_op  = (key_code == KEY_ADD) || (key_code == KEY_SUB);
  assign key_op = (key_code == KEY_SUB) ? SUB : ADD;

  always_comb begin
    clr_all  = 1'b0;
    e1_start = 1'b0;
    e1_load  = 1'b0;
    e1_dig   = 1'b0;
    e1_neg   = 1'b0;
    e2_clr   = 1'b0;
    e2_dig   = 1'b0;
    e2_neg   = 1'b0;
    if (key_valid) begin
      case (state_q)
        OP1: begin
          e1_dig  = is_dig;
          e1_neg  = (key_code == KEY_NEG);
          clr_all = (key_code == KEY_CLR);
        end
        OP2: begin
          e2_dig  = is_dig;
          e2_neg  = (key_code == KEY_NEG);
          clr_all = (key_code == KEY_CLR);
        end
        RESULT: begin
          e1_start = is_dig;
          e2_clr   = is_dig;
          clr_all  = (key_code == KEY_CLR);
`ifdef CALC_CHAIN_EN
          e1_load = is_op;
          e2_clr  = is_dig || is_op;
`endif
        end
        ERROR:   clr_all = (key_code == KEY_CLR);
        default: ;
      endcase
    end
  end

  calc_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_op1 (
    .clk(clk), .nRST(nRST), .clr_i(clr_all), .start_i(e1_start), .load_i(e1_load),
    .digit_i(e1_dig), .neg_i(e1_neg), .digit_val_i(key_code), .load_val_i(display_q),
    .accept_o(e1_acc), .value_o(e1_val), .value_next_o(e1_next)
  );

  calc_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_op2 (
    .clk(clk), .nRST(nRST), .clr_i(clr_all || e2_clr), .start_i(1'b0), .load_i(1'b0),
    .digit_i(e2_dig), .neg_i(e2_neg), .digit_val_i(key_code), .load_val_i(display_q),
    .accept_o(e2_acc), .value_o(e2_val), .value_next_o(e2_next)
  );

  assign cur_acc  = (state_q == OP1) ? e1_acc   : e2_acc;
  assign cur_next = (state_q == OP1) ? e1_next  : e2_next;
  assign cur_addr = (state_q == OP1) ? ADDR_OP1 : ADDR_OP2;
  assign cur_wr   = (is_dig && cur_acc) || (key_code == KEY_NEG);

  // Overflow judged on the operands actually handed to the ALU.
  assign ovf = alu_sub_q
             ? (alu_in1_q[WIDTH-1] != alu_in2_q[WIDTH-1]) && (alu_out[WIDTH-1] != alu_in1_q[WIDTH-1])
             : (alu_in1_q[WIDTH-1] == alu_in2_q[WIDTH-1]) && (alu_out[WIDTH-1] != alu_in1_q[WIDTH-1]);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= OP1;
      op_q         <= ADD;
      op2_dig_q    <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_sub_q    <= 1'b0;
      alu_start_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      display_q    <= '0;
      complete_q   <= 1'b0;
      error_q      <= 1'b0;
      key_reject_q <= 1'b0;
    end else begin
      alu_start_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      complete_q   <= 1'b0;
      key_reject_q <= 1'b0;
      case (state_q)
        OP1, OP2: begin
          if (key_valid) begin
            if (cur_wr) begin
              display_q   <= cur_next;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= cur_addr;
              mem_wdata_q <= cur_next;
              if (is_dig && state_q == OP2) op2_dig_q <= 1'b1;
            end else if (is_dig) begin
              key_reject_q <= 1'b1;
            end else if (is_op && (state_q == OP1 || !op2_dig_q)) begin
              op_q      <= key_op;
              op2_dig_q <= 1'b0;
              state_q   <= OP2;
            end else if (key_code == KEY_CLR) begin
              display_q <= '0;
              op2_dig_q <= 1'b0;
              state_q   <= OP1;
            end else if (key_code == KEY_EQ && state_q == OP2) begin
              // Start goes out with the SEND state so the ALU sees it one cycle after equals.
              alu_in1_q   <= e1_val;
              alu_in2_q   <= e2_val;
              alu_sub_q   <= (op_q == SUB);
              alu_start_q <= 1'b1;
              state_q     <= SEND;
            end
          end
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (alu_finish) begin
            if (ovf) begin
              display_q <= '0;
              error_q   <= 1'b1;
              state_q   <= ERROR;
            end else begin
              display_q   <= alu_out;
              complete_q  <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ADDR_RES;
              mem_wdata_q <= alu_out;
              state_q     <= RESULT;
            end
          end
        end
        RESULT: begin
          if (key_valid) begin
            if (is_dig) begin
              display_q   <= e1_next;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ADDR_OP1;
              mem_wdata_q <= e1_next;
              op2_dig_q   <= 1'b0;
              state_q     <= OP1;
            end else if (key_code == KEY_CLR) begin
              display_q <= '0;
              op2_dig_q <= 1'b0;
              state_q   <= OP1;
            end
`ifdef CALC_CHAIN_EN
            else if (is_op) begin
              op_q        <= key_op;
              op2_dig_q   <= 1'b0;
              display_q   <= e1_next;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ADDR_OP1;
              mem_wdata_q <= e1_next;
              state_q     <= OP2;
            end
`endif
          end
        end
        ERROR: begin
          if (key_valid && key_code == KEY_CLR) begin
            display_q <= '0;
            error_q   <= 1'b0;
            op2_dig_q <= 1'b0;
            state_q   <= OP1;
          end
        end
        default: state_q <= OP1;
      endcase
    end
  end

  assign alu_in1        = alu_in1_q;
  assign alu_in2        = alu_in2_q;
  assign alu_sub        = alu_sub_q;
  assign alu_start      = alu_start_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign display_output = display_q;
  assign complete       = complete_q;
  assign error          = error_q;
  assign key_reject     = key_reject_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - key-vector table plus scoreboarded ALU transactions for calc_ctrl
module tb_calc_ctrl;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] alu_in1, alu_in2, mem_wdata, display_output;
  logic [15:0] alu_out = 16'h0;
  logic        alu_finish = 1'b0;
  logic        alu_sub, alu_start, mem_we, complete, error, key_reject;
  logic [3:0]  mem_addr;

  always #5 clk = ~clk;

  calc_ctrl #(.WIDTH(16), .MAX_DIGITS(5), .AW(4), .MEM_BASE(0)) dut (
    .clk(clk), .nRST(nRST), .key_valid(key_valid), .key_code(key_code),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sub(alu_sub), .alu_start(alu_start),
    .alu_out(alu_out), .alu_finish(alu_finish), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .display_output(display_output), .complete(complete),
    .error(error), .key_reject(key_reject)
  );

  typedef struct { logic [15:0] a; logic [15:0] b; logic sub; } start_t;
  typedef struct { logic [15:0] r; bit ovf; } res_t;
  typedef struct {
    logic [3:0] key; bit calc; logic [15:0] a; logic [15:0] b; logic sub;
    logic [15:0] disp; logic rej; logic we; logic [3:0] addr; logic [15:0] wd; logic err;
  } vec_t;

  start_t sq[$];
  res_t   rq[$];
  vec_t   tbl[$];
  int     total = 0, bad = 0;
  int     alu_delay = 0, pend_cnt = 0;
  bit     pend = 0, done_seen = 0;
  logic   err_prev = 1'b0;
  logic [15:0] pa = 0, pb = 0;
  logic   psub = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    start_t s;
    res_t   r;
    @(negedge clk);
    alu_finish = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        alu_finish = 1'b1;
        alu_out    = psub ? pa - pb : pa + pb;
        pend       = 0;
      end else pend_cnt--;
    end
    if (alu_start) begin
      chk("start_expected", 32'(sq.size() != 0), 1);
      if (sq.size() != 0) begin
        s = sq.pop_front();
        chk("alu_in1", alu_in1, s.a);
        chk("alu_in2", alu_in2, s.b);
        chk("alu_sub", alu_sub, s.sub);
      end
      pend = 1; pend_cnt = alu_delay; pa = alu_in1; pb = alu_in2; psub = alu_sub;
    end
    if (complete) begin
      done_seen = 1;
      chk("result_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("result_ovf", 0, r.ovf);
        chk("result_disp", display_output, r.r);
        chk("result_we", mem_we, 1);
        chk("result_addr", mem_addr, 2);
        chk("result_wdata", mem_wdata, r.r);
      end
    end
    if (error && !err_prev) begin
      done_seen = 1;
      chk("error_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("error_ovf", 1, r.ovf);
        chk("error_disp", display_output, 0);
        chk("error_we", mem_we, 0);
      end
    end
    err_prev = error;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic push_calc(input logic [15:0] a, input logic [15:0] b, input logic sub);
    start_t s;
    res_t   r;
    int     sa, sb, sr;
    s.a = a; s.b = b; s.sub = sub;
    sq.push_back(s);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sub ? sa - sb : sa + sb;
    r.ovf = (sr > 32767) || (sr < -32768);
    r.r   = sr[15:0];
    rq.push_back(r);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 30 && !done_seen; i++) tick();
    chk({name, "_timeout"}, 32'(done_seen), 1);
  endtask

  function automatic vec_t v(input logic [3:0] k, input logic [15:0] d, input logic rj,
                             input logic we, input logic [3:0] ad, input logic [15:0] wd,
                             input logic er);
    vec_t t;
    t.key = k; t.calc = 0; t.a = 0; t.b = 0; t.sub = 0;
    t.disp = d; t.rej = rj; t.we = we; t.addr = ad; t.wd = wd; t.err = er;
    return t;
  endfunction

  function automatic vec_t c(input logic [15:0] a, input logic [15:0] b, input logic sub);
    vec_t t;
    t = v(KEY_EQ, 0, 0, 0, 0, 0, 0);
    t.calc = 1; t.a = a; t.b = b; t.sub = sub;
    return t;
  endfunction

  task automatic keys(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                      input logic [3:0] k3);
    press(k0); press(k1); press(k2); press(k3);
  endtask

  initial begin
    tick(); tick();
    chk("rst_disp", display_output, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_complete", complete, 0);
    chk("rst_error", error, 0);
    chk("rst_reject", key_reject, 0);
    nRST = 1'b1;
    tick();

    tbl.push_back(v(4'h1, 16'd1, 0, 1, 0, 16'd1, 0));
    tbl.push_back(v(4'h2, 16'd12, 0, 1, 0, 16'd12, 0));
    tbl.push_back(v(KEY_ADD, 16'd12, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'h3, 16'd3, 0, 1, 1, 16'd3, 0));
    tbl.push_back(v(4'h4, 16'd34, 0, 1, 1, 16'd34, 0));
    tbl.push_back(c(16'd12, 16'd34, 0));
    tbl.push_back(v(KEY_CLR, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'h5, 16'd5, 0, 1, 0, 16'd5, 0));
    tbl.push_back(v(KEY_NEG, 16'hFFFB, 0, 1, 0, 16'hFFFB, 0));
    tbl.push_back(v(KEY_SUB, 16'hFFFB, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'h7, 16'd7, 0, 1, 1, 16'd7, 0));
    tbl.push_back(c(16'hFFFB, 16'd7, 1));
    tbl.push_back(v(KEY_CLR, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'h3, 16'd3, 0, 1, 0, 16'd3, 0));
    tbl.push_back(v(4'h2, 16'd32, 0, 1, 0, 16'd32, 0));
    tbl.push_back(v(4'h7, 16'd327, 0, 1, 0, 16'd327, 0));
    tbl.push_back(v(4'h6, 16'd3276, 0, 1, 0, 16'd3276, 0));
    tbl.push_back(v(4'h7, 16'd32767, 0, 1, 0, 16'd32767, 0));
    tbl.push_back(v(4'h8, 16'd32767, 1, 0, 0, 0, 0));
    tbl.push_back(v(KEY_CLR, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'h3, 16'd3, 0, 1, 0, 16'd3, 0));
    tbl.push_back(v(4'h2, 16'd32, 0, 1, 0, 16'd32, 0));
    tbl.push_back(v(4'h7, 16'd327, 0, 1, 0, 16'd327, 0));
    tbl.push_back(v(4'h6, 16'd3276, 0, 1, 0, 16'd3276, 0));
    tbl.push_back(v(4'h8, 16'd3276, 1, 0, 0, 0, 0));
    tbl.push_back(v(KEY_CLR, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'h3, 16'd3, 0, 1, 0, 16'd3, 0));
    tbl.push_back(v(4'h2, 16'd32, 0, 1, 0, 16'd32, 0));
    tbl.push_back(v(4'h7, 16'd327, 0, 1, 0, 16'd327, 0));
    tbl.push_back(v(4'h6, 16'd3276, 0, 1, 0, 16'd3276, 0));
    tbl.push_back(v(4'h7, 16'd32767, 0, 1, 0, 16'd32767, 0));
    tbl.push_back(v(KEY_ADD, 16'd32767, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'h1, 16'd1, 0, 1, 1, 16'd1, 0));
    tbl.push_back(c(16'd32767, 16'd1, 0));
    tbl.push_back(v(4'h5, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(KEY_EQ, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(KEY_NEG, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(KEY_CLR, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(KEY_EQ, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].calc) begin
        push_calc(tbl[i].a, tbl[i].b, tbl[i].sub);
        done_seen = 0;
        press(KEY_EQ);
        wait_done($sformatf("v%0d_calc", i));
      end else begin
        press(tbl[i].key);
        chk($sformatf("v%0d_disp", i), display_output, tbl[i].disp);
        chk($sformatf("v%0d_reject", i), key_reject, tbl[i].rej);
        chk($sformatf("v%0d_we", i), mem_we, tbl[i].we);
        chk($sformatf("v%0d_error", i), error, tbl[i].err);
        if (tbl[i].we) begin
          chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
          chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wd);
        end
      end
    end

    keys(KEY_CLR, 4'h1, 4'h2, KEY_ADD);
    press(4'h3); press(4'h4);
    push_calc(16'd12, 16'd34, 0);
    done_seen = 0;
    press(KEY_EQ);
    wait_done("chain_first");
    press(KEY_ADD);
`ifdef CALC_CHAIN_EN
    chk("chain_op_we", mem_we, 1);
    chk("chain_op_addr", mem_addr, 0);
    chk("chain_op_wdata", mem_wdata, 46);
    press(4'h4);
    chk("chain_d_disp", display_output, 4);
    chk("chain_d_addr", mem_addr, 1);
    push_calc(16'd46, 16'd4, 0);
    done_seen = 0;
    press(KEY_EQ);
    wait_done("chain_second");
`else
    chk("nochain_op_we", mem_we, 0);
    chk("nochain_op_disp", display_output, 46);
    press(4'h4);
    chk("nochain_d_disp", display_output, 4);
    chk("nochain_d_we", mem_we, 1);
    chk("nochain_d_addr", mem_addr, 0);
    chk("nochain_d_wdata", mem_wdata, 4);
    press(KEY_EQ);
    repeat (6) tick();
    chk("nochain_eq_disp", display_output, 4);
`endif

    keys(KEY_CLR, 4'h2, KEY_ADD, 4'h3);
    alu_delay = 3;
    push_calc(16'd2, 16'd3, 0);
    done_seen = 0;
    press(KEY_EQ);
    press(KEY_CLR); press(KEY_CLR); press(KEY_CLR);
    wait_done("wait_ignore");
    chk("wait_ignore_disp", display_output, 5);

    keys(KEY_CLR, 4'h1, KEY_ADD, 4'h1);
    alu_delay = 2;
    begin
      start_t s;
      s.a = 16'd1; s.b = 16'd1; s.sub = 0;
      sq.push_back(s);
    end
    press(KEY_EQ);
    tick();
    nRST = 1'b0;
    #1;
    chk("midrst_disp", display_output, 0);
    chk("midrst_in1", alu_in1, 0);
    chk("midrst_start", alu_start, 0);
    tick();
    nRST = 1'b1;
    repeat (5) tick();
    chk("postrst_disp", display_output, 0);
    chk("postrst_complete", complete, 0);
    chk("postrst_error", error, 0);
    chk("postrst_we", mem_we, 0);
    alu_delay = 0;
    press(4'h7);
    chk("postrst_op1_disp", display_output, 7);
    chk("postrst_op1_addr", mem_addr, 0);
    chk("queues_drained", 32'(sq.size() + rq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Parametrised controller for the signed calculator. It accumulates two signed decimal operands from keypad strobes and supports add and subtract. It drives an external ALU through a start/finish handshake, detects signed overflow, and logs operands and results to the memory block. It sits between the debounced keypad front end and the `addition` ALU / `memory` pair, and replaces the fixed 16-bit add-only controller.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width, two's complement.
- `MAX_DIGITS`, 5, maximum decimal digits per operand.
- `AW`, 4, memory address width.
- `MEM_BASE`, 0, base address of the log. Operand1 is at +0, operand2 at +1, result at +2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: system clock.
  - `nRST` in 1: asynchronous, active-low reset.
- Keypad:
  - `key_valid` in 1: single-cycle strobe, already debounced and edge-detected.
  - `key_code` in 4: 0–9 are digits, `A` add, `B` sub, `C` sign toggle, `D` clear, `E` equals, `F` ignored.
- ALU:
  - `alu_in1` out WIDTH: operand 1 to the ALU.
  - `alu_in2` out WIDTH: operand 2 to the ALU.
  - `alu_sub` out 1: ALU operation select.
  - `alu_start` out 1: one-cycle start pulse.
  - `alu_out` in WIDTH: ALU result.
  - `alu_finish` in 1: ALU completion.
- Memory:
  - `mem_we` out 1: write enable.
  - `mem_addr` out AW: write address.
  - `mem_wdata` out WIDTH: write data.
- Status:
  - `display_output` out WIDTH: signed value currently shown.
  - `complete` out 1: one-cycle pulse on a valid result.
  - `error` out 1: level, high while in the ERROR state.
  - `key_reject` out 1: one-cycle pulse when a digit is refused.

## Operation
- All outputs are registered and reset to 0. The FSM resets to OP1 with both magnitudes 0 and signs positive.
- **States:** OP1, OP2, SEND, WAIT, RESULT, ERROR.
- **Digit entry (OP1/OP2):**
  - New magnitude = mag*10+d, computed at WIDTH+4 bits.
  - The digit is accepted only if the digit count is below MAX_DIGITS and the new magnitude is ≤ 2^(WIDTH-1)-1.
  - Otherwise the digit is dropped and `key_reject` pulses.
  - On an accepted digit: `display_output` shows the signed operand, and memory is written at MEM_BASE+0 (OP1) or MEM_BASE+1 (OP2).
- **Sign toggle:** flips the current operand's sign, with the same display update and memory write. It is accepted at any digit count.
- **Operator keys:**
  - In OP1: latch the op, go to OP2.
  - In OP2 before any digit: replace the latched op.
  - In OP2 after a digit: ignored.
- **Equals:**
  - In OP2: go to SEND. An empty operand2 is used as 0.
  - In OP1: ignored.
- **SEND:** `alu_in1`, `alu_in2` and `alu_sub` are loaded, `alu_start`=1 for this one cycle, then the FSM goes to WAIT.
- **WAIT:** all keys, including clear, are ignored. On `alu_finish`, the controller evaluates overflow:
  - Add overflows when sign(a)==sign(b) and sign(out)!=sign(a).
  - Sub overflows when sign(a)!=sign(b) and sign(out)!=sign(a).
  - With no overflow: go to RESULT, `display_output`=`alu_out`, `complete` pulses, memory is written at MEM_BASE+2.
  - With overflow: go to ERROR, `display_output`=0, `error`=1, no memory write.
- **RESULT:** the result is held until a key arrives.
  - A digit restarts OP1 with that digit as its first digit (operand2 cleared).
  - Clear goes to OP1 with everything zeroed.
  - Operators are handled per Configuration.
  - Sign toggle and equals are ignored.
- **ERROR:** only clear is accepted. It goes to OP1 with everything zeroed and `error`=0.
- **Clear in OP1/OP2:** zeroes both operands, signs, digit counts and display, then goes to OP1. No memory write.
- `alu_finish` outside WAIT is ignored.

## Timing
- A key strobe at cycle t takes effect at t+1: state, display, memory write and `key_reject` all update then.
- `mem_we` is high for exactly one cycle per write.
- Equals at t: SEND at t+1, `alu_start` high during t+1, WAIT from t+2.
- `alu_finish` at cycle f (in WAIT): RESULT or ERROR at f+1, with `complete`, `mem_we`, display and `error` all valid at f+1.
- Minimum equals-to-result latency is 3 cycles when the ALU finishes in the cycle after start.
- Asserting `nRST` mid-calculation returns every register to reset values immediately. Any later `alu_finish` is ignored because the FSM is no longer in WAIT.

## Configuration
- `CALC_CHAIN_EN` defined: an operator key in RESULT loads the result as operand1 and latches the op. Operand2 is cleared, the FSM goes to OP2, and memory is written at MEM_BASE+0.
- `CALC_CHAIN_EN` undefined: operator keys in RESULT are ignored.

## Structure
- Package `calc_pkg` holds:
  - the state enum `calc_state_t`;
  - the op enum `calc_op_t` (ADD, SUB);
  - localparams `KEY_ADD`, `KEY_SUB`, `KEY_NEG`, `KEY_CLR` and `KEY_EQ`.
- Sub-module `calc_entry`: one per operand. It holds the magnitude, sign and digit count, and implements the MAX_DIGITS and range check, producing `accept` and the signed value.

## Test plan
- Keys 1,2,A,3,4,E with a 1-cycle ALU:
  - `alu_start` with in1=12, in2=34, `alu_sub`=0.
  - `display_output`=46, `complete` pulses, memory address 2 gets 46.
- Keys 5,C,B,7,E:
  - in1=-5, in2=7, `alu_sub`=1.
  - The result is -12 (0xFFF4).
- Keys 3,2,7,6,7,8 with WIDTH=16:
  - The sixth digit pulses `key_reject` and the operand stays 32767.
  - Separately, 3,2,7,6,8 also rejects the final 8.
- Keys 32767,A,1,E:
  - Overflow raises `error`, `display_output`=0, no result write.
  - Keys are ignored until D; after D, `error`=0 in OP1.
- After a result of 46, key A then 4, E:
  - With `CALC_CHAIN_EN`: in1=46, the result is 50.
  - Without it: A is ignored, 4 restarts OP1 with operand1=4, and E is ignored.
- `nRST` low during WAIT, then `alu_finish` arrives:
  - All outputs stay 0 and the FSM stays in OP1.
